// File: rtl/boreal_sram_dma_ctrl.sv
// Single-channel SRAM tile DMA: copies or fills word ranges through the tile DMA port.
// Optional fill mode is compiled in only when BOREAL_DMA_FILL_EN is defined.
module boreal_sram_dma_ctrl #(
  parameter int unsigned DEPTH_LOG = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 wr,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ack,
  output logic                 m_sel,
  output logic                 m_wr,
  output logic [DEPTH_LOG-1:0] m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_ack,
  output logic                 irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_SRC    = 3'd1;
  localparam logic [2:0] OFF_DST    = 3'd2;
  localparam logic [2:0] OFF_LEN    = 3'd3;
  localparam logic [2:0] OFF_FILL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_LOG-1:0] src_q, dst_q;
  logic [DEPTH_LOG:0]   len_q;
  logic [DEPTH_LOG-1:0] sw_q, sw_d, dw_q, dw_d;
  logic [DEPTH_LOG:0]   cnt_q, cnt_d;
  logic [31:0]          hold_q, hold_d;
  logic [31:0]          rd_val, rdata_q;
  logic                 irq_en_q, busy_q, done_q, err_q, ack_q;

  logic [2:0] reg_off;
  logic       wr_en, wr_ctrl, wr_status, start_req, start_ok;
  logic       mode, start_mode;
  logic [31:0] fill;
  logic       unused_bits;

  assign reg_off   = addr[4:2];
  assign wr_en     = sel && wr;
  assign wr_ctrl   = wr_en && (reg_off == OFF_CTRL);
  assign wr_status = wr_en && (reg_off == OFF_STATUS);
  assign start_req = wr_ctrl && wdata[0];
  assign start_ok  = start_req && !busy_q;
  assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

`ifdef BOREAL_DMA_FILL_EN
  logic        mode_q;
  logic [31:0] fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      fill_q <= '0;
    end else if (wr_en && !busy_q) begin
      if (reg_off == OFF_CTRL) mode_q <= wdata[1];
      if (reg_off == OFF_FILL) fill_q <= wdata;
    end
  end

  assign mode       = mode_q;
  assign fill       = fill_q;
  // The start write also carries the mode for the transfer it launches.
  assign start_mode = wdata[1];
`else
  assign mode       = 1'b0;
  assign fill       = '0;
  assign start_mode = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_off)
      OFF_CTRL:   rd_val = {29'd0, irq_en_q, mode, 1'b0};
      OFF_SRC:    rd_val = 32'(src_q);
      OFF_DST:    rd_val = 32'(dst_q);
      OFF_LEN:    rd_val = 32'(len_q);
      OFF_FILL:   rd_val = fill;
      OFF_STATUS: rd_val = {29'd0, err_q, done_q, busy_q};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q   <= sel;
      rdata_q <= (sel && !wr) ? rd_val : '0;
      if (wr_en && !busy_q) begin
        if (reg_off == OFF_SRC) src_q <= wdata[DEPTH_LOG-1:0];
        if (reg_off == OFF_DST) dst_q <= wdata[DEPTH_LOG-1:0];
        if (reg_off == OFF_LEN) len_q <= wdata[DEPTH_LOG:0];
      end
      if (wr_ctrl) irq_en_q <= wdata[2];
      if (start_ok)              busy_q <= 1'b1;
      else if (state_q == DONE)  busy_q <= 1'b0;
      // Completion beats a same-cycle W1C clear.
      if (state_q == DONE)                         done_q <= 1'b1;
      else if (start_ok || (wr_status && wdata[1])) done_q <= 1'b0;
      if (start_req && busy_q)        err_q <= 1'b1;
      else if (wr_status && wdata[2]) err_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    dw_d    = dw_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    m_sel   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          sw_d  = src_q;
          dw_d  = dst_q;
          cnt_d = len_q;
          if (len_q == '0)     state_d = DONE;
          else if (start_mode) state_d = WR_REQ;
          else                 state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        m_sel   = 1'b1;
        m_addr  = sw_q;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_ack) begin
          hold_d  = m_rdata;
          state_d = WR_REQ;
        end else begin
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = dw_q;
        m_wdata = mode ? fill : hold_q;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (m_ack) begin
          sw_d  = sw_q + 1'b1;
          dw_d  = dw_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == (DEPTH_LOG+1)'(1)) state_d = DONE;
          else if (mode)                  state_d = WR_REQ;
          else                            state_d = RD_REQ;
        end else begin
          state_d = WR_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sw_q    <= '0;
      dw_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      dw_q    <= dw_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign irq   = done_q & irq_en_q;

endmodule

// File: tb/tb_boreal_sram_dma_ctrl.sv
// Bench for boreal_sram_dma_ctrl: tile RAM model with bus-port preemption and a write scoreboard.
module tb_boreal_sram_dma_ctrl;
  localparam int unsigned DL = 10;

  logic          clk = 1'b0;
  logic          rst, sel, wr;
  logic [31:0]   addr, wdata, rdata;
  logic          ack, m_sel, m_wr, m_ack, irq;
  logic [DL-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;

  logic          bus_hold;
  logic [31:0]   mem [0:(1<<DL)-1];
  int            checks = 0;
  int            errors = 0;
  int            msel_cnt = 0;
  logic [DL+31:0] exp_q[$];
  logic [DL+31:0] sb_exp, wr_rec;
  logic          wr_seen;

  always #5 clk = ~clk;

  boreal_sram_dma_ctrl #(.DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .irq(irq)
  );

  // Tile RAM: DMA request is served unless the bus port holds the tile this cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack   <= 1'b0;
      m_rdata <= '0;
      wr_seen <= 1'b0;
      wr_rec  <= '0;
    end else begin
      m_ack   <= 1'b0;
      wr_seen <= 1'b0;
      if (m_sel) begin
        msel_cnt++;
        if (!bus_hold) begin
          m_ack   <= 1'b1;
          m_rdata <= mem[m_addr];
          if (m_wr) begin
            mem[m_addr] = m_wdata;
            wr_seen <= 1'b1;
            wr_rec  <= {m_addr, m_wdata};
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wr_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got %h want none", wr_rec);
      end else begin
        sb_exp = exp_q.pop_front();
        if (wr_rec !== sb_exp) begin
          errors++;
          $display("FAIL sb_write got %h want %h", wr_rec, sb_exp);
        end
      end
    end
  end

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d, output logic k);
    sel = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0; addr = '0;
    d = rdata; k = ack;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (irq) begin cyc = k; break; end
    end
  endtask

  task automatic push_copy(input logic [DL-1:0] s, input logic [DL-1:0] d, input int n);
    logic [DL-1:0] sa, da;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({da, mem[sa]});
      sa = sa + 1'b1; da = da + 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic k;
    checks++;
    if ({m_sel, m_wr, irq, ack, m_addr, m_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %b %b want 0", m_sel, m_wr, irq, ack);
    end
    for (int i = 0; i < 8; i++) begin
      cfg_read(32'(i * 4), d, k);
      checks++;
      if (d !== 32'h0 || k !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg%0d got %h ack %b want 0 ack 1", i, d, k);
      end
    end
    @(negedge clk);
    checks++;
    if (rdata !== 32'h0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_bus got %h ack %b want 0 ack 0", rdata, ack);
    end
  endtask

  task automatic test_regs;
    logic [31:0] d; logic k;
    cfg_write(32'h04, 32'hFFFF_FFFF);
    cfg_read(32'h04, d, k);
    checks++; if (d !== 32'h3FF) begin errors++; $display("FAIL src_width got %h want %h", d, 32'h3FF); end
    cfg_write(32'h08, 32'h0001_2345);
    cfg_read(32'h08, d, k);
    checks++; if (d !== 32'h345) begin errors++; $display("FAIL dst_width got %h want %h", d, 32'h345); end
    cfg_write(32'h0C, 32'hFFFF_FFFF);
    cfg_read(32'h0C, d, k);
    checks++; if (d !== 32'h7FF) begin errors++; $display("FAIL len_width got %h want %h", d, 32'h7FF); end
    cfg_write(32'h18, 32'hFFFF_FFFF);
    cfg_read(32'h18, d, k);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", d); end
    cfg_write(32'h00, 32'h6);
    cfg_read(32'h00, d, k);
`ifdef BOREAL_DMA_FILL_EN
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ctrl_rb got %h want %h", d, 32'h6); end
`else
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL ctrl_rb got %h want %h", d, 32'h4); end
`endif
    cfg_write(32'h10, 32'h1234_5678);
    cfg_read(32'h10, d, k);
`ifdef BOREAL_DMA_FILL_EN
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL fill_rb got %h want %h", d, 32'h1234_5678); end
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fill_rb got %h want 0", d); end
`endif
    cfg_write(32'h14, 32'h7);
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_ro got %h want 0", d); end
    cfg_write(32'h00, 32'h0);
  endtask

  task automatic test_copy;
    logic [31:0] d; logic k; int cyc;
    cfg_write(32'h04, 32'h010);
    cfg_write(32'h08, 32'h200);
    cfg_write(32'h0C, 32'd4);
    push_copy(10'h010, 10'h200, 4);
    msel_cnt = 0;
    cfg_write(32'h00, 32'h5);
    wait_irq(cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL copy_latency got %0d want 17", cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL copy_missing got %0d want 0", exp_q.size()); end
    checks++; if (msel_cnt !== 8) begin errors++; $display("FAIL copy_msel got %0d want 8", msel_cnt); end
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL copy_status got %h want 2", d); end
    cfg_write(32'h14, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL copy_irq_clr got %b want 0", irq); end
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL copy_w1c got %h want 0", d); end
  endtask

`ifdef BOREAL_DMA_FILL_EN
  task automatic test_fill;
    int cyc; logic [DL-1:0] da;
    cfg_write(32'h08, 32'h3FE);
    cfg_write(32'h0C, 32'd4);
    cfg_write(32'h10, 32'hA5A5_A5A5);
    da = 10'h3FE;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({da, 32'hA5A5_A5A5});
      da = da + 1'b1;
    end
    msel_cnt = 0;
    cfg_write(32'h00, 32'h7);
    wait_irq(cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL fill_latency got %0d want 9", cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL fill_missing got %0d want 0", exp_q.size()); end
    checks++; if (msel_cnt !== 4 * 2) begin errors++; $display("FAIL fill_msel got %0d want 8", msel_cnt); end
    cfg_write(32'h14, 32'h2);
  endtask
`endif

  task automatic test_preempt;
    int cyc;
    cfg_write(32'h04, 32'h040);
    cfg_write(32'h08, 32'h100);
    cfg_write(32'h0C, 32'd3);
    push_copy(10'h040, 10'h100, 3);
    msel_cnt = 0;
    cfg_write(32'h00, 32'h5);
    bus_hold = 1'b1;
    repeat (5) @(negedge clk);
    bus_hold = 1'b0;
    wait_irq(cyc);
    checks++; if (cyc !== 14) begin errors++; $display("FAIL preempt_latency got %0d want 14", cyc); end
    checks++; if (msel_cnt !== 9) begin errors++; $display("FAIL preempt_msel got %0d want 9", msel_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL preempt_missing got %0d want 0", exp_q.size()); end
    cfg_write(32'h14, 32'h2);
  endtask

  task automatic test_len0;
    logic [31:0] d; logic k;
    cfg_write(32'h0C, 32'd0);
    msel_cnt = 0;
    cfg_write(32'h00, 32'h5);
    cfg_write(32'h14, 32'h2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL len0_done got %b want 1", irq); end
    repeat (3) @(negedge clk);
    checks++; if (msel_cnt !== 0) begin errors++; $display("FAIL len0_msel got %0d want 0", msel_cnt); end
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL len0_status got %h want 2", d); end
    cfg_write(32'h14, 32'h2);
  endtask

  task automatic test_busy;
    logic [31:0] d; logic k; int cyc;
    cfg_write(32'h04, 32'h020);
    cfg_write(32'h08, 32'h300);
    cfg_write(32'h0C, 32'd4);
    push_copy(10'h020, 10'h300, 4);
    msel_cnt = 0;
    cfg_write(32'h00, 32'h5);
    cfg_write(32'h00, 32'h5);
    cfg_write(32'h0C, 32'd9);
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL busy_status got %h want 5", d); end
    cfg_read(32'h0C, d, k);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL busy_len got %h want 4", d); end
    wait_irq(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL busy_timeout got %0d want >0", cyc); end
    checks++; if (exp_q.size() !== 0 || msel_cnt !== 8) begin
      errors++; $display("FAIL busy_xfer got %0d/%0d want 0/8", exp_q.size(), msel_cnt);
    end
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL busy_final got %h want 6", d); end
    cfg_write(32'h14, 32'h6);
    cfg_read(32'h14, d, k);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL busy_w1c got %h want 0", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic k; bit found; int snap;
    cfg_write(32'h04, 32'h010);
    cfg_write(32'h08, 32'h280);
    cfg_write(32'h0C, 32'd8);
    push_copy(10'h010, 10'h280, 8);
    msel_cnt = 0;
    cfg_write(32'h00, 32'h5);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_sel && !m_wr && msel_cnt >= 4) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach got %0d want 1", found); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({m_sel, m_wr, irq, ack, m_addr, m_wdata, rdata} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got %b %b %h want 0", m_sel, m_wr, m_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    snap = msel_cnt;
    for (int i = 0; i < 6; i++) begin
      cfg_read(32'(i * 4), d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_reg%0d got %h want 0", i, d); end
    end
    checks++; if (msel_cnt !== snap) begin errors++; $display("FAIL rst_mid_msel got %0d want %0d", msel_cnt, snap); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << DL); i++) mem[i] = $urandom;
    rst = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; bus_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_regs;
    test_copy;
`ifdef BOREAL_DMA_FILL_EN
    test_fill;
`endif
    test_preempt;
    test_len0;
    test_busy;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boreal_sram_dma_ctrl.md
BOREAL_SRAM_DMA_CTRL -- requirements
Module: boreal_sram_dma_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 10, tile word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports sel/wr  input  1/1  config bus select and write.
REQ-005 SHALL have ports addr/wdata  input  32/32  config byte address and write data.
REQ-006 SHALL have ports rdata/ack  output  32/1  config read data and 1-cycle ack.
REQ-007 SHALL have ports m_sel/m_wr  output  1/1  tile DMA-port request and write.
REQ-008 SHALL have ports m_addr/m_wdata  output  DEPTH_LOG/32  tile word address and write data.
REQ-009 SHALL have ports m_rdata/m_ack  input  32/1  tile DMA read data and ack, both valid in the cycle after a served request.
REQ-010 SHALL have port irq  output  1  level interrupt = STATUS.done & CTRL.irq_en.

Function
REQ-011 SHALL decode addr[4:2]: 0 CTRL, 1 SRC, 2 DST, 3 LEN, 4 FILL, 5 STATUS; other offsets read 0 and ignore writes.
REQ-012 SHALL define CTRL as bit0 start (write-1 pulse, reads 0), bit1 mode (0 copy, 1 fill), bit2 irq_en.
REQ-013 SHALL define SRC/DST as DEPTH_LOG-bit word addresses and LEN as a DEPTH_LOG+1-bit word count; upper bits read 0.
REQ-014 SHALL define STATUS as bit0 busy (RO), bit1 done (W1C), bit2 err (W1C).
REQ-015 SHALL register ack high exactly one cycle after any cycle with sel=1, and rdata in the same cycle; rdata is 0 otherwise.
REQ-016 SHALL ignore writes to SRC, DST, LEN, FILL and CTRL.mode while busy=1.
REQ-017 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-018 SHALL, on start in IDLE, load working src, dst and count from SRC, DST and LEN, clear done, set busy, and enter RD_REQ (copy) or WR_REQ (fill).
REQ-019 SHALL, when start is written with LEN=0, go directly to DONE without asserting m_sel.
REQ-020 SHALL drive m_sel=1 for exactly one cycle in each *_REQ state and m_sel=0 in every other state.
REQ-021 SHALL, in *_WAIT, return to the same *_REQ when m_ack=0 (preempted by the bus port) and advance when m_ack=1; retries are unbounded.
REQ-022 SHALL, in copy mode, capture m_rdata into a holding register on the RD_WAIT ack and drive it on m_wdata in WR_REQ.
REQ-023 SHALL, in fill mode, drive FILL on m_wdata.
REQ-024 SHALL, on the WR_WAIT ack, increment src and dst modulo 2^DEPTH_LOG, decrement count, and enter DONE if count reaches 0, else RD_REQ (copy) or WR_REQ (fill).
REQ-025 SHALL take 4 cycles per copied word and 2 cycles per filled word when there is no preemption.
REQ-026 SHALL, in DONE, set STATUS.done, clear busy, and return to IDLE on the next cycle.
REQ-027 SHALL ignore start while busy=1 and set STATUS.err instead.
REQ-028 SHALL let a set condition win over a same-cycle W1C clear on done or err.

Reset
REQ-029 SHALL clear on rst all registers, the FSM (to IDLE), rdata, ack, m_sel, m_wr, m_addr, m_wdata and irq, abandoning any in-flight transfer with m_sel=0 in the next cycle.

Configuration
REQ-030 SHALL compile fill mode only when macro BOREAL_DMA_FILL_EN is defined.
REQ-031 SHALL, without BOREAL_DMA_FILL_EN, hold CTRL.mode at 0 and FILL at 0 on read, ignore writes to both, and support copy only.

Verification
REQ-032 SHALL cover copy: SRC=0x010, DST=0x200, LEN=4, start, no contention -> words 0x010..0x013 appear at 0x200..0x203, done set 17 cycles after start, irq=1 when irq_en=1.
REQ-033 SHALL cover fill (macro on): DST=0x3FE, LEN=4, FILL=0xA5A5A5A5 -> 0x3FE, 0x3FF, 0x000, 0x001 written (address wrap).
REQ-034 SHALL cover preemption: bus port held sel for 5 cycles during RD_REQ -> m_sel reissued each retry and data still correct.
REQ-035 SHALL cover LEN=0 start -> m_sel never asserted, done=1 within 2 cycles.
REQ-036 SHALL cover start while busy and a write of LEN=9 while busy -> err=1, LEN unchanged, transfer unaffected.
REQ-037 SHALL cover rst asserted mid-copy -> m_sel=0 and busy=0 immediately, all registers read 0 afterwards.
